// File: rtl/hwpe_ctrl_ucode_loader_pkg.sv
// hwpe_ctrl_package
// Shared types for the HWPE microcode engine and its loader. ucode_t is the
// program image the engine executes; the loader-specific items are the image
// magic, the field offsets of the packed 32-bit image words, the loader error
// codes and the loader FSM states.
package hwpe_ctrl_package;

  localparam int unsigned UCODE_LENGTH    = 16;
  localparam int unsigned UCODE_NB_LOOPS  = 6;
  localparam int unsigned UCODE_CNT_WIDTH = 16;

  typedef struct packed {
    logic       op_sel;
    logic [4:0] a;
    logic [4:0] b;
  } uloop_code_t;

  typedef struct packed {
    logic [7:0] ucode_addr;
    logic [7:0] nb_ops;
  } uloop_loops_t;

  typedef struct packed {
    uloop_code_t  [UCODE_LENGTH-1:0]                      code;
    uloop_loops_t [UCODE_NB_LOOPS-1:0]                    loops;
    logic         [UCODE_NB_LOOPS-1:0][UCODE_CNT_WIDTH-1:0] range;
  } ucode_t;

  localparam logic [15:0] UCODE_MAGIC = 16'hC0DE;

  // Header word: magic | nb_used loops | nb_instr
  localparam int unsigned HDR_MAGIC_LSB    = 16;
  localparam int unsigned HDR_NB_USED_LSB  = 8;
  localparam int unsigned HDR_NB_INSTR_LSB = 0;

  // Instruction slot (16 bits, two per code word, low slot first)
  localparam int unsigned SLOT_WIDTH     = 16;
  localparam int unsigned SLOT_RSVD_LSB  = 11;
  localparam int unsigned SLOT_OP_SEL    = 10;
  localparam int unsigned SLOT_A_LSB     = 5;
  localparam int unsigned SLOT_B_LSB     = 0;

  // Loop descriptor word: range | ucode_addr | nb_ops
  localparam int unsigned DESC_RANGE_LSB  = 16;
  localparam int unsigned DESC_ADDR_LSB   = 8;
  localparam int unsigned DESC_NB_OPS_LSB = 0;
  localparam logic [7:0]  DESC_MAX_NB_OPS = 8'd8;

  typedef enum logic [2:0] {
    UCODE_LOADER_ERR_NONE  = 3'd0,
    UCODE_LOADER_ERR_MAGIC = 3'd1,
    UCODE_LOADER_ERR_HDR   = 3'd2,
    UCODE_LOADER_ERR_RSVD  = 3'd3,
    UCODE_LOADER_ERR_DESC  = 3'd4
  } ucode_loader_err_t;

  typedef enum logic [2:0] {
    UCODE_LOADER_IDLE,
    UCODE_LOADER_CODE,
    UCODE_LOADER_LOOPS,
    UCODE_LOADER_COMMIT,
    UCODE_LOADER_ERROR
  } ucode_loader_state_t;

  // Fresh staging image: empty code, every loop a harmless single pass over
  // one instruction, so loops the image does not describe stay benign.
  function automatic ucode_t ucode_staging_init();
    ucode_t u;
    u = '0;
    for (int l = 0; l < int'(UCODE_NB_LOOPS); l++) begin
      u.loops[l].ucode_addr = 8'd0;
      u.loops[l].nb_ops     = 8'd1;
      u.range[l]            = UCODE_CNT_WIDTH'(1);
    end
    return u;
  endfunction

endpackage

// File: rtl/hwpe_ctrl_ucode_loader_check.sv
// hwpe_ctrl_ucode_loader_check
// Combinational validator for the three kinds of image word. All three
// verdicts are computed from the same stream word; the loader picks the one
// matching its current state.
// Ports:
//   word_i           stream word under inspection
//   nb_instr_i       instruction count of the image being loaded
//   code_hi_ignore_i upper slot of this code word is padding (odd count)
//   hdr_err_o        verdict if word_i is a header
//   code_err_o       verdict if word_i is a code word
//   desc_err_o       verdict if word_i is a loop descriptor
module hwpe_ctrl_ucode_loader_check
  import hwpe_ctrl_package::*;
#(
  parameter int unsigned LENGTH     = 16,
  parameter int unsigned NB_LOOPS   = 6,
  parameter int unsigned NB_ENG_REG = 32,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic [31:0]       word_i,
  input  logic [7:0]        nb_instr_i,
  input  logic              code_hi_ignore_i,
  output ucode_loader_err_t hdr_err_o,
  output ucode_loader_err_t code_err_o,
  output ucode_loader_err_t desc_err_o
);

  localparam logic [7:0] LENGTH_B     = 8'(LENGTH);
  localparam logic [7:0] NB_LOOPS_B   = 8'(NB_LOOPS);
  localparam logic [5:0] NB_ENG_REG_B = 6'(NB_ENG_REG);

  logic [7:0]           hdr_nb_instr;
  logic [7:0]           hdr_nb_used;
  logic [CNT_WIDTH-1:0] desc_range;
  logic [7:0]           desc_addr;
  logic [7:0]           desc_nb_ops;
  logic [8:0]           desc_end;

  assign hdr_nb_instr = word_i[HDR_NB_INSTR_LSB +: 8];
  assign hdr_nb_used  = word_i[HDR_NB_USED_LSB +: 8];
  assign desc_range   = word_i[DESC_RANGE_LSB +: CNT_WIDTH];
  assign desc_addr    = word_i[DESC_ADDR_LSB +: 8];
  assign desc_nb_ops  = word_i[DESC_NB_OPS_LSB +: 8];
  assign desc_end     = {1'b0, desc_addr} + {1'b0, desc_nb_ops};

  // A slot is legal when its reserved bits are clear and both operands name
  // a register the engine actually has.
  function automatic logic slot_ok(input logic [15:0] slot);
    logic [4:0] a;
    logic [4:0] b;
    a = slot[SLOT_A_LSB +: 5];
    b = slot[SLOT_B_LSB +: 5];
    return (slot[15:SLOT_RSVD_LSB] == '0) &&
           ({1'b0, a} < NB_ENG_REG_B) && ({1'b0, b} < NB_ENG_REG_B);
  endfunction

  always_comb begin
    hdr_err_o  = UCODE_LOADER_ERR_NONE;
    code_err_o = UCODE_LOADER_ERR_NONE;
    desc_err_o = UCODE_LOADER_ERR_NONE;

    if (word_i[HDR_MAGIC_LSB +: 16] != UCODE_MAGIC) begin
      hdr_err_o = UCODE_LOADER_ERR_MAGIC;
    end else if ((hdr_nb_instr == 8'd0) || (hdr_nb_instr > LENGTH_B) ||
                 (hdr_nb_used == 8'd0) || (hdr_nb_used > NB_LOOPS_B)) begin
      hdr_err_o = UCODE_LOADER_ERR_HDR;
    end

    if (!slot_ok(word_i[15:0]) ||
        (!code_hi_ignore_i && !slot_ok(word_i[31:16]))) begin
      code_err_o = UCODE_LOADER_ERR_RSVD;
    end

    // The end of the loop body may touch but not pass the last instruction.
    if ((desc_range == '0) || (desc_nb_ops == 8'd0) ||
        (desc_nb_ops > DESC_MAX_NB_OPS) || (desc_end > {1'b0, nb_instr_i})) begin
      desc_err_o = UCODE_LOADER_ERR_DESC;
    end
  end

endmodule

// File: rtl/hwpe_ctrl_ucode_loader.sv
// hwpe_ctrl_ucode_loader
// Writer side of the microcode interface. Receives a packed image (header,
// code words, loop descriptors) on a valid/ready stream, validates each word
// as it arrives, assembles it in a private staging copy and only then commits
// it to the engine in a single cycle, so the engine never sees a half-written
// program.
// Ports:
//   clk_i, rst_ni   clock, asynchronous active-low reset
//   clear_i         synchronous abort: back to idle, everything zeroed
//   word_valid_i    stream word valid
//   word_i          stream word
//   word_ready_o    loader accepts a word (state and engine_busy_i only)
//   engine_busy_i   engine executing; holds off a new header
//   ucode_o         committed program
//   ucode_clear_o   one-cycle clear pulse to the engine on commit
//   loaded_o        committed program valid
//   error_o         sticky load error
//   err_code_o      cause of the load error
// LENGTH, NB_LOOPS and CNT_WIDTH must not exceed the ucode_t dimensions.
module hwpe_ctrl_ucode_loader
  import hwpe_ctrl_package::*;
#(
  parameter int unsigned LENGTH    = 16,
  parameter int unsigned NB_LOOPS  = 6,
  parameter int unsigned NB_REG    = 4,
  parameter int unsigned NB_RO_REG = 28,
  parameter int unsigned CNT_WIDTH = 16
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        clear_i,
  input  logic        word_valid_i,
  input  logic [31:0] word_i,
  output logic        word_ready_o,
  input  logic        engine_busy_i,
  output ucode_t      ucode_o,
  output logic        ucode_clear_o,
  output logic        loaded_o,
  output logic        error_o,
  output logic [2:0]  err_code_o
);

  ucode_loader_state_t state_q, state_d;
  ucode_loader_err_t   hdr_err, code_err, desc_err;
  ucode_loader_err_t   err_code_q;

  ucode_t     staging_q;
  ucode_t     ucode_q;
  logic [7:0] nb_instr_q;
  logic [7:0] nb_used_q;
  logic [7:0] word_cnt_q;
  logic [7:0] loop_cnt_q;
  logic       loaded_q;
  logic       error_q;

  logic       word_fire;
  logic [8:0] nb_code_words;
  logic       last_code_word;
  logic       last_loop;
  logic       code_hi_ignore;

  assign word_fire      = word_valid_i & word_ready_o;
  assign nb_code_words  = ({1'b0, nb_instr_q} + 9'd1) >> 1;
  assign last_code_word = ({1'b0, word_cnt_q} == (nb_code_words - 9'd1));
  assign last_loop      = ({1'b0, loop_cnt_q} == ({1'b0, nb_used_q} - 9'd1));
  // An odd instruction count leaves the upper slot of the final code word as
  // padding; whatever it holds is neither checked nor stored.
  assign code_hi_ignore = nb_instr_q[0] & last_code_word;

  hwpe_ctrl_ucode_loader_check #(
    .LENGTH     (LENGTH),
    .NB_LOOPS   (NB_LOOPS),
    .NB_ENG_REG (NB_REG + NB_RO_REG),
    .CNT_WIDTH  (CNT_WIDTH)
  ) i_check (
    .word_i           (word_i),
    .nb_instr_i       (nb_instr_q),
    .code_hi_ignore_i (code_hi_ignore),
    .hdr_err_o        (hdr_err),
    .code_err_o       (code_err),
    .desc_err_o       (desc_err)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= UCODE_LOADER_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and handshake/pulse outputs. clear_i overrides whatever the
  // stream is doing; ready deliberately ignores it so that it stays a pure
  // function of state and engine_busy_i.
  always_comb begin
    state_d       = state_q;
    word_ready_o  = 1'b0;
    ucode_clear_o = 1'b0;
    case (state_q)
      UCODE_LOADER_IDLE: begin
        word_ready_o = ~engine_busy_i;
        if (word_fire) begin
          state_d = (hdr_err == UCODE_LOADER_ERR_NONE) ? UCODE_LOADER_CODE
                                                       : UCODE_LOADER_ERROR;
        end
      end
      UCODE_LOADER_CODE: begin
        word_ready_o = 1'b1;
        if (word_fire) begin
          if (code_err != UCODE_LOADER_ERR_NONE) begin
            state_d = UCODE_LOADER_ERROR;
          end else if (last_code_word) begin
            state_d = UCODE_LOADER_LOOPS;
          end
        end
      end
      UCODE_LOADER_LOOPS: begin
        word_ready_o = 1'b1;
        if (word_fire) begin
          if (desc_err != UCODE_LOADER_ERR_NONE) begin
            state_d = UCODE_LOADER_ERROR;
          end else if (last_loop) begin
            state_d = UCODE_LOADER_COMMIT;
          end
        end
      end
      UCODE_LOADER_COMMIT: begin
        ucode_clear_o = 1'b1;
        state_d       = UCODE_LOADER_IDLE;
      end
      UCODE_LOADER_ERROR: begin
        state_d = UCODE_LOADER_ERROR;
      end
      default: begin
        state_d = UCODE_LOADER_IDLE;
      end
    endcase
    if (clear_i) begin
      state_d       = UCODE_LOADER_IDLE;
      ucode_clear_o = 1'b0;
    end
  end

  // Datapath: header capture, staging assembly, commit and error recording.
  // The committed image is touched only in COMMIT or on clear.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      staging_q  <= '0;
      ucode_q    <= '0;
      nb_instr_q <= '0;
      nb_used_q  <= '0;
      word_cnt_q <= '0;
      loop_cnt_q <= '0;
      loaded_q   <= 1'b0;
      error_q    <= 1'b0;
      err_code_q <= UCODE_LOADER_ERR_NONE;
    end else if (clear_i) begin
      staging_q  <= '0;
      ucode_q    <= '0;
      nb_instr_q <= '0;
      nb_used_q  <= '0;
      word_cnt_q <= '0;
      loop_cnt_q <= '0;
      loaded_q   <= 1'b0;
      error_q    <= 1'b0;
      err_code_q <= UCODE_LOADER_ERR_NONE;
    end else begin
      case (state_q)
        UCODE_LOADER_IDLE: begin
          if (word_fire) begin
            loaded_q   <= 1'b0;
            word_cnt_q <= '0;
            loop_cnt_q <= '0;
            nb_instr_q <= word_i[HDR_NB_INSTR_LSB +: 8];
            nb_used_q  <= word_i[HDR_NB_USED_LSB +: 8];
            staging_q  <= ucode_staging_init();
            if (hdr_err != UCODE_LOADER_ERR_NONE) begin
              error_q    <= 1'b1;
              err_code_q <= hdr_err;
            end
          end
        end
        UCODE_LOADER_CODE: begin
          if (word_fire) begin
            if (code_err != UCODE_LOADER_ERR_NONE) begin
              error_q    <= 1'b1;
              err_code_q <= code_err;
            end else begin
              for (int s = 0; s < int'(UCODE_LENGTH); s++) begin
                if ((8'(s / 2) == word_cnt_q) && (8'(s) < nb_instr_q)) begin
                  staging_q.code[s] <= word_i[(s % 2) * SLOT_WIDTH +: 11];
                end
              end
              word_cnt_q <= word_cnt_q + 8'd1;
            end
          end
        end
        UCODE_LOADER_LOOPS: begin
          if (word_fire) begin
            if (desc_err != UCODE_LOADER_ERR_NONE) begin
              error_q    <= 1'b1;
              err_code_q <= desc_err;
            end else begin
              for (int l = 0; l < int'(UCODE_NB_LOOPS); l++) begin
                if (8'(l) == loop_cnt_q) begin
                  staging_q.loops[l] <= word_i[15:0];
                  staging_q.range[l] <=
                    UCODE_CNT_WIDTH'(word_i[DESC_RANGE_LSB +: CNT_WIDTH]);
                end
              end
              loop_cnt_q <= loop_cnt_q + 8'd1;
            end
          end
        end
        UCODE_LOADER_COMMIT: begin
          ucode_q  <= staging_q;
          loaded_q <= 1'b1;
        end
        default: begin
        end
      endcase
    end
  end

  assign ucode_o    = ucode_q;
  assign loaded_o   = loaded_q;
  assign error_o    = error_q;
  assign err_code_o = err_code_q;

endmodule

// File: tb/tb_hwpe_ctrl_ucode_loader.sv
// tb_hwpe_ctrl_ucode_loader
// Directed bench for the microcode loader: reset state, a full load with its
// commit timing, each error cause, busy back-pressure on reloads, and an
// abort in the middle of an image.
module tb_hwpe_ctrl_ucode_loader;
  import hwpe_ctrl_package::*;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        clear_i;
  logic        word_valid_i;
  logic [31:0] word_i;
  logic        word_ready_o;
  logic        engine_busy_i;
  ucode_t      ucode_o;
  logic        ucode_clear_o;
  logic        loaded_o;
  logic        error_o;
  logic [2:0]  err_code_o;

  int checks = 0;
  int errors = 0;

  ucode_t exp_u1;
  ucode_t exp_u2;

  hwpe_ctrl_ucode_loader dut (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .clear_i       (clear_i),
    .word_valid_i  (word_valid_i),
    .word_i        (word_i),
    .word_ready_o  (word_ready_o),
    .engine_busy_i (engine_busy_i),
    .ucode_o       (ucode_o),
    .ucode_clear_o (ucode_clear_o),
    .loaded_o      (loaded_o),
    .error_o       (error_o),
    .err_code_o    (err_code_o)
  );

  always #5 clk_i = ~clk_i;

  // Compare one observed value against its hand-computed expectation.
  task automatic checkOutput(input string tag, input logic [511:0] observed,
                             input logic [511:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Offer one word and hold it until accepted; called and returns #1 after
  // a rising edge, the return edge being the accepting one.
  task automatic applyStimulus(input logic [31:0] w);
    int waited;
    waited = 0;
    word_valid_i = 1'b1;
    word_i       = w;
    while (!word_ready_o && waited < 20) begin
      @(posedge clk_i);
      #1;
      waited++;
    end
    if (!word_ready_o) begin
      checks++;
      errors++;
      $error("[TB] FAIL handshake_timeout observed=ready0 expected=ready1 word=%0h", w);
    end else begin
      @(posedge clk_i);
      #1;
    end
    word_valid_i = 1'b0;
    word_i       = '0;
  endtask

  task automatic pulseClear();
    clear_i = 1'b1;
    @(posedge clk_i);
    #1;
    clear_i = 1'b0;
  endtask

  task automatic loadImage1();
    applyStimulus(32'hC0DE_0103);
    applyStimulus(32'h0421_0443);
    applyStimulus(32'h0000_0462);
    applyStimulus(32'h0004_0003);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=running expected=finished");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    // Expected images, written out field by field.
    exp_u1 = '0;
    for (int l = 0; l < 6; l++) begin
      exp_u1.loops[l].ucode_addr = 8'd0;
      exp_u1.loops[l].nb_ops     = 8'd1;
      exp_u1.range[l]            = 16'd1;
    end
    exp_u2 = exp_u1;
    exp_u1.code[0]         = {1'b1, 5'd2, 5'd3};
    exp_u1.code[1]         = {1'b1, 5'd1, 5'd1};
    exp_u1.code[2]         = {1'b1, 5'd3, 5'd2};
    exp_u1.loops[0].nb_ops = 8'd3;
    exp_u1.range[0]        = 16'd4;
    exp_u2.code[0]         = {1'b1, 5'd1, 5'd2};
    exp_u2.range[1]        = 16'd3;

    rst_ni        = 1'b0;
    clear_i       = 1'b0;
    word_valid_i  = 1'b0;
    word_i        = '0;
    engine_busy_i = 1'b0;
    #1;
    checkOutput("rst_ready", word_ready_o, 1'b1);
    checkOutput("rst_ucode", ucode_o, '0);
    checkOutput("rst_clear", ucode_clear_o, 1'b0);
    checkOutput("rst_loaded", loaded_o, 1'b0);
    checkOutput("rst_error", error_o, 1'b0);
    checkOutput("rst_errcode", err_code_o, 3'd0);
    repeat (2) @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
    @(posedge clk_i);
    #1;

    $display("[TB] full load");
    loadImage1();
    checkOutput("commit_pulse", ucode_clear_o, 1'b1);
    checkOutput("commit_ready", word_ready_o, 1'b0);
    checkOutput("commit_loaded_pre", loaded_o, 1'b0);
    checkOutput("commit_ucode_pre", ucode_o, '0);
    @(posedge clk_i);
    #1;
    checkOutput("load1_pulse_end", ucode_clear_o, 1'b0);
    checkOutput("load1_loaded", loaded_o, 1'b1);
    checkOutput("load1_code0", ucode_o.code[0], {1'b1, 5'd2, 5'd3});
    checkOutput("load1_code1", ucode_o.code[1], {1'b1, 5'd1, 5'd1});
    checkOutput("load1_code2", ucode_o.code[2], {1'b1, 5'd3, 5'd2});
    checkOutput("load1_range0", ucode_o.range[0], 16'd4);
    checkOutput("load1_range5", ucode_o.range[5], 16'd1);
    checkOutput("load1_image", ucode_o, exp_u1);
    checkOutput("load1_ready", word_ready_o, 1'b1);

    $display("[TB] bad descriptor");
    applyStimulus(32'hC0DE_0106);
    checkOutput("reload_loaded_drop", loaded_o, 1'b0);
    applyStimulus(32'h0000_0000);
    applyStimulus(32'h0000_0000);
    applyStimulus(32'h0000_0000);
    applyStimulus(32'h0002_0205);
    checkOutput("desc_error", error_o, 1'b1);
    checkOutput("desc_errcode", err_code_o, 3'd4);
    checkOutput("desc_ready", word_ready_o, 1'b0);
    checkOutput("desc_no_pulse", ucode_clear_o, 1'b0);
    checkOutput("desc_keep_ucode", ucode_o, exp_u1);
    @(posedge clk_i);
    #1;
    checkOutput("desc_sticky", err_code_o, 3'd4);
    checkOutput("desc_no_pulse2", ucode_clear_o, 1'b0);
    pulseClear();
    checkOutput("clr_error", error_o, 1'b0);
    checkOutput("clr_errcode", err_code_o, 3'd0);
    checkOutput("clr_ucode", ucode_o, '0);
    checkOutput("clr_ready", word_ready_o, 1'b1);

    $display("[TB] bad magic");
    applyStimulus(32'hBEEF_0101);
    checkOutput("magic_error", error_o, 1'b1);
    checkOutput("magic_errcode", err_code_o, 3'd1);
    checkOutput("magic_ready", word_ready_o, 1'b0);
    pulseClear();
    checkOutput("magic_clr_error", error_o, 1'b0);
    checkOutput("magic_clr_ready", word_ready_o, 1'b1);

    $display("[TB] bad header counts");
    applyStimulus(32'hC0DE_0701);
    checkOutput("hdr_errcode", err_code_o, 3'd2);
    pulseClear();
    applyStimulus(32'hC0DE_0111);
    checkOutput("hdr_len_errcode", err_code_o, 3'd2);
    pulseClear();

    $display("[TB] reserved slot bits");
    applyStimulus(32'hC0DE_0102);
    applyStimulus(32'h0000_1000);
    checkOutput("rsvd_error", error_o, 1'b1);
    checkOutput("rsvd_errcode", err_code_o, 3'd3);
    pulseClear();

    $display("[TB] busy engine blocks reload");
    loadImage1();
    @(posedge clk_i);
    #1;
    checkOutput("busy_pre_loaded", loaded_o, 1'b1);
    engine_busy_i = 1'b1;
    word_valid_i  = 1'b1;
    word_i        = 32'hC0DE_0201;
    repeat (3) @(posedge clk_i);
    #1;
    checkOutput("busy_ready", word_ready_o, 1'b0);
    checkOutput("busy_loaded_held", loaded_o, 1'b1);
    checkOutput("busy_ucode_held", ucode_o, exp_u1);
    engine_busy_i = 1'b0;
    #1;
    checkOutput("unbusy_ready", word_ready_o, 1'b1);
    @(posedge clk_i);
    #1;
    word_valid_i = 1'b0;
    checkOutput("unbusy_loaded_drop", loaded_o, 1'b0);
    // Upper slot carries reserved bits but is padding for a 1-instruction image.
    applyStimulus(32'hF800_0422);
    applyStimulus(32'h0001_0001);
    applyStimulus(32'h0003_0001);
    checkOutput("load2_pulse", ucode_clear_o, 1'b1);
    checkOutput("load2_no_error", error_o, 1'b0);
    @(posedge clk_i);
    #1;
    checkOutput("load2_loaded", loaded_o, 1'b1);
    checkOutput("load2_image", ucode_o, exp_u2);

    $display("[TB] clear mid-image");
    applyStimulus(32'hC0DE_0103);
    applyStimulus(32'h0421_0443);
    word_valid_i = 1'b1;
    word_i       = 32'h0000_0462;
    clear_i      = 1'b1;
    @(posedge clk_i);
    #1;
    clear_i      = 1'b0;
    word_valid_i = 1'b0;
    checkOutput("abort_ucode", ucode_o, '0);
    checkOutput("abort_loaded", loaded_o, 1'b0);
    checkOutput("abort_pulse", ucode_clear_o, 1'b0);
    checkOutput("abort_error", error_o, 1'b0);
    engine_busy_i = 1'b1;
    #1;
    checkOutput("abort_idle", word_ready_o, 1'b0);
    engine_busy_i = 1'b0;
    #1;
    loadImage1();
    checkOutput("reload_pulse", ucode_clear_o, 1'b1);
    @(posedge clk_i);
    #1;
    checkOutput("reload_loaded", loaded_o, 1'b1);
    checkOutput("reload_image", ucode_o, exp_u1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
